// File: rtl/prog_clock_div.sv
// Multi-channel programmable divider: each channel yields a per-period tick and
// either a 50% square wave or a one-cycle strobe, with divisor changes taking effect only at period boundaries.
module prog_clock_div #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 17
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] divisor,
    output logic [NUM_CH-1:0]       div_clock,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : ch_g
            logic [CNT_W-1:0] count_q, count_d;
            logic [CNT_W-1:0] active_q, active_d;
            logic [CNT_W-1:0] shadow_q, shadow_d;
            logic             dclk_q, dclk_d;
            logic             tick_q, tick_d;
            logic             pend_q, pend_d;
            logic [CNT_W-1:0] slice;
            logic             at_end;

            assign slice  = divisor[gi*CNT_W +: CNT_W];
            assign at_end = (count_q == (active_q - ONE));

            always_comb begin
                count_d  = count_q;
                active_d = active_q;
                shadow_d = shadow_q;
                dclk_d   = dclk_q;
                tick_d   = 1'b0;
                pend_d   = pend_q;

                if (enable[gi]) begin
                    if (at_end) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        dclk_d  = mode[gi] ? 1'b1 : ~dclk_q;
                        if (pend_q) begin
                            active_d = shadow_q;
                            pend_d   = 1'b0;
                        end
                    end else begin
                        count_d = count_q + ONE;
                        if (mode[gi]) begin
                            dclk_d = 1'b0;
                        end
                    end
                end else begin
                    if (mode[gi]) begin
                        dclk_d = 1'b0;
                    end
                    // An idle channel has no period to finish, so a queued divisor starts a fresh period now.
                    if (pend_q) begin
                        active_d = shadow_q;
                        pend_d   = 1'b0;
                        count_d  = '0;
                    end
                end

                // Load is applied last so a boundary-coincident load queues behind the promoted shadow.
                if (load[gi]) begin
                    shadow_d = (slice == '0) ? ONE : slice;
                    pend_d   = 1'b1;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    count_q  <= '0;
                    active_q <= DEF_DIV;
                    shadow_q <= DEF_DIV;
                    dclk_q   <= 1'b0;
                    tick_q   <= 1'b0;
                    pend_q   <= 1'b0;
                end else begin
                    count_q  <= count_d;
                    active_q <= active_d;
                    shadow_q <= shadow_d;
                    dclk_q   <= dclk_d;
                    tick_q   <= tick_d;
                    pend_q   <= pend_d;
                end
            end

            assign div_clock[gi] = dclk_q;
            assign tick[gi]      = tick_q;
            assign pending[gi]   = pend_q;
        end
    endgenerate

endmodule
